// File: rtl/muldiv_ctrl.sv
// Signed/unsigned RV32M front end for an unsigned multu/divu engine: decodes funct3,
// forms operand magnitudes, runs one engine op, then fixes signs and selects the result.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            md_valid,
    output logic            md_mode,
    output logic [XLEN-1:0] md_in_A,
    output logic [XLEN-1:0] md_in_B,
    input  logic            md_ready,
    input  logic [63:0]     md_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_funct3;
    logic            r_sa;
    logic            r_sb;
    logic [XLEN-1:0] r_md_in_a;
    logic [XLEN-1:0] r_md_in_b;
    logic            r_md_mode;
    logic            r_md_valid;
    logic            r_resp_valid;
    logic [XLEN-1:0] r_resp_data;

    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_div_zero;
    logic            w_overflow;
    logic [XLEN-1:0] w_special_res;
    logic [63:0]     w_prod;
    logic [XLEN-1:0] w_result;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    // |0x80000000| wraps back to 0x80000000, which the unsigned engine reads correctly
    function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? neg32(x) : x;
    endfunction

    // Accept-time decode: operand signedness and engine-free special cases
    always_comb begin
        w_a_signed    = 1'b0;
        w_b_signed    = 1'b0;
        w_special_res = 32'h0000_0000;
        case (req_funct3)
            3'b001:         begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            3'b010:         begin w_a_signed = 1'b1; w_b_signed = 1'b0; end
            3'b100, 3'b110: begin w_a_signed = 1'b1; w_b_signed = 1'b1; end
            default:        begin w_a_signed = 1'b0; w_b_signed = 1'b0; end
        endcase
        w_div_zero = req_funct3[2] && (req_rs2 == 32'h0000_0000);
        w_overflow = req_funct3[2] && !req_funct3[0] &&
                     (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
        if (w_div_zero) begin
            w_special_res = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
        end else if (w_overflow) begin
            w_special_res = req_funct3[1] ? 32'h0000_0000 : 32'h8000_0000;
        end else begin
            w_special_res = 32'h0000_0000;
        end
    end

    // Sign fix-up and result selection from the engine output
    always_comb begin
        w_prod   = (r_sa ^ r_sb) ? (~md_out + 64'd1) : md_out;
        w_result = 32'h0000_0000;
        if (!r_funct3[2]) begin
            w_result = (r_funct3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
        end else if (r_funct3[1]) begin
            w_result = r_sa ? neg32(md_out[63:32]) : md_out[63:32];
        end else begin
            w_result = (r_sa ^ r_sb) ? neg32(md_out[31:0]) : md_out[31:0];
        end
    end

    // Control FSM with registered engine and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_funct3     <= 3'b000;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_md_in_a    <= 32'h0000_0000;
            r_md_in_b    <= 32'h0000_0000;
            r_md_mode    <= 1'b0;
            r_md_valid   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 32'h0000_0000;
        end else begin
            r_md_valid   <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= req_funct3;
                        r_sa      <= w_a_signed & req_rs1[31];
                        r_sb      <= w_b_signed & req_rs2[31];
                        r_md_in_a <= mag32(req_rs1, w_a_signed);
                        r_md_in_b <= mag32(req_rs2, w_b_signed);
                        r_md_mode <= req_funct3[2];
                        if (w_div_zero || w_overflow) begin
                            r_resp_data  <= w_special_res;
                            r_resp_valid <= 1'b1;
                            r_state      <= DONE;
                        end else begin
                            r_md_valid <= 1'b1;
                            r_state    <= ISSUE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (md_ready) begin
                        r_resp_data  <= w_result;
                        r_resp_valid <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_state <= WAIT;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign stall      = ((r_state == IDLE) && req_valid) || (r_state == ISSUE) || (r_state == WAIT);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign md_valid   = r_md_valid;
    assign md_mode    = r_md_mode;
    assign md_in_A    = r_md_in_a;
    assign md_in_B    = r_md_in_b;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural unsigned multu/divu engine.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        md_valid;
    logic        md_mode;
    logic [31:0] md_in_A;
    logic [31:0] md_in_B;
    logic        md_ready;
    logic [63:0] md_out;

    int passed = 0;
    int total  = 0;
    int md_pulses = 0;
    int eng_lat = 2;
    int eng_cnt = 0;
    logic [63:0] eng_res;
    logic [31:0] cap_a, cap_b;
    logic        cap_mode;

    muldiv_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .stall(stall), .resp_valid(resp_valid),
        .resp_data(resp_data), .md_valid(md_valid), .md_mode(md_mode),
        .md_in_A(md_in_A), .md_in_B(md_in_B), .md_ready(md_ready), .md_out(md_out)
    );

    always #5 clk = ~clk;

    // Engine model: md_ready pulses eng_lat cycles after the md_valid edge
    always @(posedge clk) begin
        if (rst) begin
            eng_cnt  <= 0;
            md_ready <= 1'b0;
        end else begin
            md_ready <= 1'b0;
            if (md_valid) begin
                md_pulses <= md_pulses + 1;
                cap_a     <= md_in_A;
                cap_b     <= md_in_B;
                cap_mode  <= md_mode;
                if (md_mode)
                    eng_res <= (md_in_B == 32'd0) ? 64'd0 : {md_in_A % md_in_B, md_in_A / md_in_B};
                else
                    eng_res <= {32'd0, md_in_A} * {32'd0, md_in_B};
                eng_cnt <= eng_lat;
            end else if (eng_cnt == 1) begin
                md_ready <= 1'b1;
                md_out   <= eng_res;
                eng_cnt  <= 0;
            end else if (eng_cnt > 1) begin
                eng_cnt <= eng_cnt - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Issue one op; latency counts edges from the accept edge to the first resp_valid cycle
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input int exp_lat, input int exp_pulses);
        int n;
        int p0;
        @(negedge clk);
        p0 = md_pulses;
        req_valid = 1'b1; req_funct3 = f3; req_rs1 = a; req_rs2 = b;
        #1;
        check({tag, ".stall_accept"}, {63'd0, stall}, 64'd1);
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!resp_valid && n < 60);
        check({tag, ".resp_valid"}, {63'd0, resp_valid}, 64'd1);
        check({tag, ".data"}, {32'd0, resp_data}, {32'd0, exp});
        check({tag, ".latency"}, n, exp_lat);
        check({tag, ".stall_done"}, {63'd0, stall}, 64'd0);
        // req_valid stays high across the DONE edge; it must not be re-accepted
        @(posedge clk); #1;
        req_valid = 1'b0;
        check({tag, ".resp_pulse"}, {63'd0, resp_valid}, 64'd0);
        @(posedge clk); #1;
        check({tag, ".idle_stall"}, {63'd0, stall}, 64'd0);
        check({tag, ".hold"}, {32'd0, resp_data}, {32'd0, exp});
        check({tag, ".md_pulses"}, md_pulses - p0, exp_pulses);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; req_funct3 = 3'b000;
        req_rs1 = 32'd0; req_rs2 = 32'd0; md_out = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.stall", {63'd0, stall}, 64'd0);
        check("rst.resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst.md_valid", {63'd0, md_valid}, 64'd0);
        check("rst.md_mode", {63'd0, md_mode}, 64'd0);
        check("rst.resp_data", {32'd0, resp_data}, 64'd0);
        check("rst.md_in_A", {32'd0, md_in_A}, 64'd0);
        check("rst.md_in_B", {32'd0, md_in_B}, 64'd0);
        rst = 1'b0;

        // Normal ops: 3 + eng_lat(2) = 5; special cases: 1
        run_op("mul",    3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 5, 1);
        check("mul.eng_a", {32'd0, cap_a}, 64'd7);
        check("mul.eng_b", {32'd0, cap_b}, 64'hFFFF_FFFD);
        run_op("mulh",   3'b001, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 5, 1);
        check("mulh.eng_b", {32'd0, cap_b}, 64'd3);
        run_op("mulhu",  3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1);
        run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 1);
        check("mulhsu.eng_a", {32'd0, cap_a}, 64'd1);
        check("mulhsu.eng_mode", {63'd0, cap_mode}, 64'd0);
        run_op("div",    3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 5, 1);
        check("div.eng_a", {32'd0, cap_a}, 64'd7);
        check("div.eng_mode", {63'd0, cap_mode}, 64'd1);
        run_op("rem",    3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 5, 1);
        run_op("divu",   3'b101, 32'd100,      32'd7,         32'd14,        5, 1);
        run_op("remu",   3'b111, 32'd100,      32'd7,         32'd2,         5, 1);
        run_op("div0",   3'b100, 32'd5,        32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("remu0",  3'b111, 32'd5,        32'd0,         32'd5,         1, 0);
        run_op("rem0",   3'b110, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 1, 0);
        run_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1, 0);
        run_op("divuovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       5, 1);

        // Reset while the engine is busy: op dropped, no response
        eng_lat = 10;
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b011; req_rs1 = 32'd9; req_rs2 = 32'd9;
        repeat (3) @(posedge clk);
        #1;
        check("abort.stall_wait", {63'd0, stall}, 64'd1);
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        check("abort.stall", {63'd0, stall}, 64'd0);
        check("abort.resp_valid", {63'd0, resp_valid}, 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (resp_valid || stall) seen++;
        end
        check("abort.quiet", seen, 0);
        eng_lat = 2;
        run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 5, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
